// File: rtl/ahb_data_buffer.sv
// Shared byte FIFO between the AHB slave decoder and the USB side.
// AHB moves 1/2/4 bytes per access; the USB side moves one byte per cycle.
module ahb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_tx_data,
  input  logic              get_rx_data,
  input  logic [1:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              rx_byte_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_byte_pop,
  input  logic              clear,
  output logic [31:0]       rx_data,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W:0]   occupancy,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  function automatic logic [2:0] size_n(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W-1:0] wptr;
  logic              wr_pend;
  logic [2:0]        wr_n;

  logic [2:0]  rd_n;
  logic [2:0]  wr_cnt;
  logic [2:0]  rd_cnt;
  logic [2:0]  push_cnt;
  logic [2:0]  pop_cnt;
  logic [CW:0] occ_x;
  logic        wr_ok;
  logic        rx_ok;
  logic        rd_ok;
  logic        tx_ok;
  logic [31:0] rd_word;

  // Capacity checks use only start-of-cycle occupancy.
  always_comb begin
    occ_x    = {1'b0, occupancy};
    rd_n     = size_n(hsize);
    wr_ok    = wr_pend &&
               (occ_x + (CW+1)'(wr_n) <= CAP);
    wr_cnt   = wr_ok ? wr_n : 3'd0;
    rx_ok    = rx_byte_valid &&
               (occ_x + (CW+1)'(wr_cnt)
                + (CW+1)'(1) <= CAP);
    rd_ok    = get_rx_data &&
               ((CW+1)'(rd_n) <= occ_x);
    rd_cnt   = rd_ok ? rd_n : 3'd0;
    tx_ok    = tx_byte_pop &&
               (occ_x > (CW+1)'(rd_cnt));
    push_cnt = wr_cnt + {2'b00, rx_ok};
    pop_cnt  = rd_cnt + {2'b00, tx_ok};
    rd_word  = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < rd_n)
        rd_word[8*i +: 8] =
          mem[rptr + ADDR_W'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_ok && 3'(i) < wr_n)
          mem[wptr + ADDR_W'(i)] <=
            hwdata[8*i +: 8];
      end
      if (rx_ok)
        mem[wptr + ADDR_W'(wr_cnt)] <= rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr      <= '0;
      wptr      <= '0;
      occupancy <= '0;
      wr_pend   <= 1'b0;
      wr_n      <= 3'd0;
      rx_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      rptr      <= '0;
      wptr      <= '0;
      occupancy <= '0;
      wr_pend   <= 1'b0;
      wr_n      <= 3'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr + ADDR_W'(push_cnt);
      rptr      <= rptr + ADDR_W'(pop_cnt);
      occupancy <= occupancy + CW'(push_cnt)
                   - CW'(pop_cnt);
      wr_pend   <= store_tx_data;
      wr_n      <= size_n(hsize);
      if (rd_ok)
        rx_data <= rd_word;
      if ((wr_pend && !wr_ok) ||
          (rx_byte_valid && !rx_ok))
        overflow <= 1'b1;
      if ((get_rx_data && !rd_ok) ||
          (tx_byte_pop && !tx_ok))
        underflow <= 1'b1;
    end
  end

  assign buf_empty = (occupancy == '0);
  assign buf_full  = (occupancy == FULL);
  assign tx_byte   = buf_empty ? 8'h00 : mem[rptr];

endmodule

// File: tb/tb_ahb_data_buffer.sv
// Bench for ahb_data_buffer: queue-based byte model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_ahb_data_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        store_tx_data = 1'b0;
  logic        get_rx_data = 1'b0;
  logic [1:0]  hsize = 2'b00;
  logic [31:0] hwdata = '0;
  logic        rx_byte_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        tx_byte_pop = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] rx_data;
  logic [7:0]  tx_byte;
  logic [6:0]  occupancy;
  logic        buf_empty;
  logic        buf_full;
  logic        overflow;
  logic        underflow;

  always #5 clk = ~clk;

  ahb_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .store_tx_data(store_tx_data),
    .get_rx_data(get_rx_data),
    .hsize(hsize),
    .hwdata(hwdata),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte(rx_byte),
    .tx_byte_pop(tx_byte_pop),
    .clear(clear),
    .rx_data(rx_data),
    .tx_byte(tx_byte),
    .occupancy(occupancy),
    .buf_empty(buf_empty),
    .buf_full(buf_full),
    .overflow(overflow),
    .underflow(underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  q[$];
  bit          m_pend = 0;
  int          m_wn = 0;
  logic [31:0] m_rx = '0;
  bit          m_ovf = 0;
  bit          m_udf = 0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue updated from start-of-cycle state.
  always @(posedge clk) begin : model
    int occ0;
    int rn;
    int wtake;
    int rtake;
    logic [31:0] w;
    if (rst) begin
      q.delete();
      m_pend = 0;
      m_rx = '0;
      m_ovf = 0;
      m_udf = 0;
    end else if (clear) begin
      q.delete();
      m_pend = 0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      occ0 = q.size();
      wtake = 0;
      rtake = 0;
      if (get_rx_data) begin
        rn = nbytes(hsize);
        if (rn <= occ0) begin
          w = '0;
          for (int i = 0; i < rn; i++)
            w[8*i +: 8] = q.pop_front();
          m_rx = w;
          rtake = rn;
        end else m_udf = 1;
      end
      if (tx_byte_pop) begin
        if (occ0 - rtake >= 1) void'(q.pop_front());
        else m_udf = 1;
      end
      if (m_pend) begin
        if (occ0 + m_wn <= 64) begin
          for (int i = 0; i < m_wn; i++)
            q.push_back(hwdata[8*i +: 8]);
          wtake = m_wn;
        end else m_ovf = 1;
      end
      if (rx_byte_valid) begin
        if (occ0 + wtake + 1 <= 64) q.push_back(rx_byte);
        else m_ovf = 1;
      end
      m_pend = store_tx_data;
      m_wn = nbytes(hsize);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
      chk("buf_full", 32'(buf_full), 32'(q.size() == 64));
      chk("tx_byte", 32'(tx_byte),
          32'((q.size() != 0) ? q[0] : 8'h00));
      chk("rx_data", rx_data, m_rx);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    store_tx_data = 0;
    get_rx_data = 0;
    rx_byte_valid = 0;
    tx_byte_pop = 0;
    clear = 0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_byte_valid = 1;
    rx_byte = b;
    tick();
    rx_byte_valid = 0;
  endtask

  logic [7:0] exp1 [4];
  int phase;

  initial begin
    exp1[0] = 8'hAA; exp1[1] = 8'hBB;
    exp1[2] = 8'hCC; exp1[3] = 8'hDD;
    idle();
    rst = 1;
    repeat (2) tick();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_full", 32'(buf_full), 32'd0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    rst = 0;
    tick();

    // word write then drain through the USB side
    store_tx_data = 1; hsize = 2'b10;
    tick();
    store_tx_data = 0; hwdata = 32'hDDCCBBAA;
    tick();
    hwdata = '0;
    chk("w_occ4", 32'(occupancy), 32'd4);
    chk("w_head", 32'(tx_byte), 32'hAA);
    for (int i = 0; i < 4; i++) begin
      chk("w_order", 32'(tx_byte), 32'(exp1[i]));
      tx_byte_pop = 1;
      tick();
      tx_byte_pop = 0;
    end
    chk("w_empty", 32'(buf_empty), 32'd1);

    // fill to capacity, then overflow
    do_clear();
    for (int i = 0; i < 60; i++) rx_push(8'(i));
    store_tx_data = 1; hsize = 2'b10;
    tick();
    store_tx_data = 0; hwdata = $urandom;
    tick();
    chk("f_occ64", 32'(occupancy), 32'd64);
    chk("f_full", 32'(buf_full), 32'd1);
    chk("f_ovf0", 32'(overflow), 32'd0);
    rx_push(8'hFF);
    chk("f_ovf1", 32'(overflow), 32'd1);
    chk("f_occ_hold", 32'(occupancy), 32'd64);

    // rejected word read, then halfword read
    do_clear();
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    get_rx_data = 1; hsize = 2'b10;
    tick();
    get_rx_data = 0;
    chk("r_udf", 32'(underflow), 32'd1);
    chk("r_rx_hold", rx_data, 32'd0);
    chk("r_occ3", 32'(occupancy), 32'd3);
    get_rx_data = 1; hsize = 2'b01;
    tick();
    get_rx_data = 0;
    chk("r_rx_half", rx_data, 32'h00002211);
    chk("r_occ1", 32'(occupancy), 32'd1);

    // pointer wrap
    do_clear();
    for (int i = 0; i < 50; i++) rx_push(8'($urandom));
    tx_byte_pop = 1; repeat (50) tick(); tx_byte_pop = 0;
    for (int i = 0; i < 20; i++) rx_push(8'($urandom));
    tx_byte_pop = 1; repeat (20) tick(); tx_byte_pop = 0;
    chk("wrap_occ0", 32'(occupancy), 32'd0);

    // concurrent AHB commit + USB push + USB pop at occupancy 5
    do_clear();
    for (int i = 1; i <= 4; i++) rx_push(8'(i));
    rx_byte_valid = 1; rx_byte = 8'h05;
    store_tx_data = 1; hsize = 2'b01;
    tick();
    store_tx_data = 0;
    rx_byte = 8'h77; hwdata = 32'h0000A2A1;
    tx_byte_pop = 1;
    tick();
    idle();
    chk("mix_occ7", 32'(occupancy), 32'd7);
    chk("mix_head", 32'(tx_byte), 32'h02);
    tx_byte_pop = 1; repeat (4) tick(); tx_byte_pop = 0;
    chk("mix_ahb0", 32'(tx_byte), 32'hA1);
    tx_byte_pop = 1; tick(); tx_byte_pop = 0;
    chk("mix_ahb1", 32'(tx_byte), 32'hA2);
    tx_byte_pop = 1; tick(); tx_byte_pop = 0;
    chk("mix_usb", 32'(tx_byte), 32'h77);

    // clear during the write data phase
    do_clear();
    tx_byte_pop = 1; tick(); tx_byte_pop = 0;
    chk("c_udf_set", 32'(underflow), 32'd1);
    store_tx_data = 1; hsize = 2'b10;
    tick();
    store_tx_data = 0; clear = 1; hwdata = 32'h12345678;
    tick();
    clear = 0;
    chk("c_occ0", 32'(occupancy), 32'd0);
    chk("c_flags", {30'd0, overflow, underflow}, 32'd0);
    chk("c_rx_held", rx_data, 32'h00002211);
    tick();
    chk("c_occ0_later", 32'(occupancy), 32'd0);

    // random traffic with fill/drain bias
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) phase = int'($urandom_range(0, 2));
      idle();
      clear = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: store_tx_data = 1;
        1: get_rx_data = 1;
        default: ;
      endcase
      hsize = 2'($urandom);
      hwdata = $urandom;
      rx_byte = 8'($urandom);
      rx_byte_valid = (phase == 0) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 3) == 0);
      tx_byte_pop = (phase == 1) ? ($urandom_range(0, 3) != 0)
                                 : ($urandom_range(0, 2) == 0);
      if (phase == 1 && store_tx_data) begin
        store_tx_data = 0;
        get_rx_data = 1;
      end
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
